// File: rtl/srl_fifo_pkg.sv
// Shared constants and helpers for the SRL16E-based FIFO controller.
// Holds the SRL geometry and the occupancy-counter update rule.
package srl_fifo_pkg;

    localparam int SRL_DEPTH = 16;
    localparam int SRL_AW    = 4;
    localparam int LVL_W     = 5;

    // A simultaneous push and load leaves the count unchanged.
    function automatic logic [LVL_W-1:0] next_cnt(
        input logic [LVL_W-1:0] cnt,
        input logic             push,
        input logic             load,
        input logic             flush
    );
        logic [LVL_W-1:0] n;
        n = cnt;
        if (flush)
            n = '0;
        else if (push && !load)
            n = cnt + 1'b1;
        else if (load && !push)
            n = cnt - 1'b1;
        return n;
    endfunction

endpackage

// File: rtl/srl16e.sv
// Behavioural model of the 16-bit addressable shift-register primitive.
// No reset: contents start from INIT and only change on CE.
module SRL16E #(
    parameter logic [15:0] INIT            = 16'h0,
    parameter bit          IS_CLK_INVERTED = 1'b0
) (
    output logic Q,
    input  logic A0,
    input  logic A1,
    input  logic A2,
    input  logic A3,
    input  logic CE,
    input  logic CLK,
    input  logic D
);

    logic [15:0] sr = INIT;

    generate
        if (IS_CLK_INVERTED) begin : g_neg
            always_ff @(negedge CLK)
                if (CE) sr <= {sr[14:0], D};
        end else begin : g_pos
            always_ff @(posedge CLK)
                if (CE) sr <= {sr[14:0], D};
        end
    endgenerate

    assign Q = sr[{A3, A2, A1, A0}];

endmodule

// File: rtl/srl16_fifo_ctrl.sv
// 16-deep FIFO built from WIDTH SRL16E primitives plus a registered output.
// Oldest word always sits at address cnt-1; total capacity is 17 words.
module srl16_fifo_ctrl
    import srl_fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int AFULL_LVL = 12
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             FLUSH,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] IN_DATA,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] OUT_DATA,
    output logic [LVL_W-1:0] LEVEL,
    output logic             ALMOST_FULL
);

    localparam logic [LVL_W-1:0] FULL = LVL_W'(SRL_DEPTH);
    localparam logic [LVL_W-1:0] AFL  = LVL_W'(AFULL_LVL);

    logic [LVL_W-1:0]  cnt;
    logic [LVL_W-1:0]  cnt_m1;
    logic [SRL_AW-1:0] addr;
    logic [WIDTH-1:0]  srl_q;
    logic              push;
    logic              load;

    assign IN_READY    = (cnt != FULL);
    assign push        = IN_VALID & IN_READY & ~FLUSH;
    assign load        = (cnt != '0) & (~OUT_VALID | OUT_READY) & ~FLUSH;
    assign cnt_m1      = cnt - 1'b1;
    assign addr        = (cnt != '0) ? cnt_m1[SRL_AW-1:0] : '0;
    assign LEVEL       = cnt;
    assign ALMOST_FULL = (cnt >= AFL);

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_srl
            SRL16E #(
                .INIT            (16'h0),
                .IS_CLK_INVERTED (1'b0)
            ) u_srl (
                .Q   (srl_q[i]),
                .A0  (addr[0]),
                .A1  (addr[1]),
                .A2  (addr[2]),
                .A3  (addr[3]),
                .CE  (push),
                .CLK (CLK),
                .D   (IN_DATA[i])
            );
        end
    endgenerate

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            cnt <= '0;
        else
            cnt <= next_cnt(cnt, push, load, FLUSH);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            OUT_VALID <= 1'b0;
            OUT_DATA  <= '0;
        end else if (FLUSH) begin
            OUT_VALID <= 1'b0;
        end else if (load) begin
            OUT_VALID <= 1'b1;
            OUT_DATA  <= srl_q;
        end else if (OUT_VALID && OUT_READY) begin
            OUT_VALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_srl16_fifo_ctrl.sv
// Directed bench for srl16_fifo_ctrl: vector table plus corner sequences.
// Outputs are sampled 1 time unit after each rising edge.
module tb_srl16_fifo_ctrl;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [4:0] level;
    logic       almost_full;

    int passed = 0;
    int total  = 0;

    srl16_fifo_ctrl #(.WIDTH(8), .AFULL_LVL(12)) dut (
        .CLK         (clk),
        .RST_N       (rst_n),
        .FLUSH       (flush),
        .IN_VALID    (in_valid),
        .IN_READY    (in_ready),
        .IN_DATA     (in_data),
        .OUT_VALID   (out_valid),
        .OUT_READY   (out_ready),
        .OUT_DATA    (out_data),
        .LEVEL       (level),
        .ALMOST_FULL (almost_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       fl;
        logic       iv;
        logic [7:0] id;
        logic       ordy;
        logic       ir;
        logic       ov;
        logic [7:0] od;
        logic [4:0] lv;
        logic       af;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp)
            passed++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic drive(input logic fl, input logic iv,
                         input logic [7:0] d, input logic ordy);
        flush     = fl;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(0, 0, 8'h00, 1);
        rst_n = 1'b0;
        #12;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_afull", int'(almost_full), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        vt[0] = '{0, 0, 8'h00, 1, 1, 0, 8'h00, 5'd0, 0};
        vt[1] = '{0, 1, 8'hA5, 1, 1, 0, 8'h00, 5'd1, 0};
        vt[2] = '{0, 0, 8'h00, 1, 1, 1, 8'hA5, 5'd0, 0};
        vt[3] = '{0, 0, 8'h00, 1, 1, 0, 8'hA5, 5'd0, 0};
        vt[4] = '{0, 1, 8'h11, 0, 1, 0, 8'hA5, 5'd1, 0};
        vt[5] = '{0, 1, 8'h22, 0, 1, 1, 8'h11, 5'd1, 0};
        vt[6] = '{0, 0, 8'h00, 0, 1, 1, 8'h11, 5'd1, 0};
        vt[7] = '{0, 0, 8'h00, 1, 1, 1, 8'h22, 5'd0, 0};
        vt[8] = '{1, 1, 8'h99, 0, 1, 0, 8'h22, 5'd0, 0};
        vt[9] = '{0, 0, 8'h00, 0, 1, 0, 8'h22, 5'd0, 0};

        for (int i = 0; i < 10; i++) begin
            drive(vt[i].fl, vt[i].iv, vt[i].id, vt[i].ordy);
            tick();
            chk($sformatf("vec%0d_in_ready", i), int'(in_ready), int'(vt[i].ir));
            chk($sformatf("vec%0d_out_valid", i), int'(out_valid), int'(vt[i].ov));
            chk($sformatf("vec%0d_out_data", i), int'(out_data), int'(vt[i].od));
            chk($sformatf("vec%0d_level", i), int'(level), int'(vt[i].lv));
            chk($sformatf("vec%0d_afull", i), int'(almost_full), int'(vt[i].af));
        end

        // Fill: 17 words with the output stalled.
        for (int i = 0; i < 17; i++) begin
            chk($sformatf("fill%0d_in_ready", i), int'(in_ready), 1);
            drive(0, 1, 8'(i), 0);
            tick();
            chk($sformatf("fill%0d_level", i), int'(level), (i == 0) ? 1 : i);
            chk($sformatf("fill%0d_afull", i), int'(almost_full),
                (((i == 0) ? 1 : i) >= 12) ? 1 : 0);
        end
        chk("full_in_ready", int'(in_ready), 0);
        chk("full_out_data", int'(out_data), 0);
        chk("full_out_valid", int'(out_valid), 1);
        drive(0, 1, 8'h55, 0);
        tick();
        chk("full_hold_level", int'(level), 16);
        chk("full_hold_out_data", int'(out_data), 0);
        drive(0, 0, 8'h00, 1);
        for (int k = 0; k < 17; k++) begin
            chk($sformatf("drain%0d_valid", k), int'(out_valid), 1);
            chk($sformatf("drain%0d_data", k), int'(out_data), k);
            tick();
        end
        chk("drain_end_valid", int'(out_valid), 0);
        chk("drain_end_level", int'(level), 0);

        // Streaming at full rate.
        for (int j = 0; j < 100; j++) begin
            drive(0, 1, 8'(8'h40 + j), 1);
            tick();
            if (j == 0) begin
                chk("stream0_level", int'(level), 1);
                chk("stream0_valid", int'(out_valid), 0);
            end else begin
                chk($sformatf("stream%0d_level", j), int'(level), 1);
                chk($sformatf("stream%0d_valid", j), int'(out_valid), 1);
                chk($sformatf("stream%0d_data", j), int'(out_data),
                    int'(8'(8'h40 + j - 1)));
            end
        end
        drive(0, 0, 8'h00, 1);
        tick();
        chk("stream_tail_data", int'(out_data), int'(8'(8'h40 + 99)));
        chk("stream_tail_level", int'(level), 0);
        tick();
        chk("stream_idle_valid", int'(out_valid), 0);

        // Flush at level 5 with a concurrent push.
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, 8'(8'hB0 + i), 0);
            tick();
        end
        chk("pre_flush_level", int'(level), 5);
        drive(1, 1, 8'h77, 0);
        tick();
        chk("flush_level", int'(level), 0);
        chk("flush_valid", int'(out_valid), 0);
        drive(0, 1, 8'h3C, 1);
        tick();
        chk("post_flush_level", int'(level), 1);
        drive(0, 0, 8'h00, 1);
        tick();
        chk("post_flush_valid", int'(out_valid), 1);
        chk("post_flush_data", int'(out_data), 8'h3C);
        tick();

        // Asynchronous reset mid-stream at level 9.
        for (int i = 0; i < 10; i++) begin
            drive(0, 1, 8'(8'hC0 + i), 0);
            tick();
        end
        chk("pre_rst_level", int'(level), 9);
        chk("pre_rst_valid", int'(out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_level", int'(level), 0);
        chk("arst_valid", int'(out_valid), 0);
        chk("arst_data", int'(out_data), 0);
        chk("arst_in_ready", int'(in_ready), 1);
        drive(0, 0, 8'h00, 1);
        #3;
        rst_n = 1'b1;
        tick();
        drive(0, 1, 8'h11, 1);
        tick();
        chk("rel_level", int'(level), 1);
        chk("rel_valid0", int'(out_valid), 0);
        drive(0, 1, 8'h22, 1);
        tick();
        chk("rel_valid1", int'(out_valid), 1);
        chk("rel_data1", int'(out_data), 8'h11);
        drive(0, 0, 8'h00, 1);
        tick();
        chk("rel_valid2", int'(out_valid), 1);
        chk("rel_data2", int'(out_data), 8'h22);
        tick();
        chk("rel_valid3", int'(out_valid), 0);
        chk("rel_level_end", int'(level), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/srl16_fifo_ctrl.md
Name: srl16_fifo_ctrl

Overview:
- Controller that turns a bank of WIDTH SRL16E shift-register primitives into a 16-deep synchronous FIFO with valid/ready handshakes on both sides.
- Generates the shared SRL clock enable and the 4-bit read address (A3..A0) from an occupancy counter.
- Adds a registered output stage, so downstream timing never sees the SRL address-to-Q path.
- Used wherever a small, LUT-cheap elastic buffer is needed between pipeline stages.

Parameters:
- WIDTH, 8, data word width; equals the number of SRL16E instances.
- AFULL_LVL, 12, occupancy (1..16) at or above which ALMOST_FULL asserts.

Ports:
- CLK  in  1  clock; all logic on the rising edge; SRL16E instances use IS_CLK_INVERTED=0.
- RST_N  in  1  asynchronous, active-low reset.
- FLUSH  in  1  synchronous clear of FIFO state.
- IN_VALID  in  1  write request.
- IN_READY  out  1  FIFO can accept a word.
- IN_DATA  in  WIDTH  write data.
- OUT_VALID  out  1  output register holds a valid word.
- OUT_READY  in  1  downstream accepts the word.
- OUT_DATA  out  WIDTH  output register contents.
- LEVEL  out  5  words held in the SRL bank (0..16); excludes the output register.
- ALMOST_FULL  out  1  LEVEL >= AFULL_LVL.

Behaviour:
- Reset (RST_N low, asynchronous):
  - cnt=0, OUT_VALID=0, OUT_DATA=0, so IN_READY=1, LEVEL=0, ALMOST_FULL=0.
  - SRL contents are not reset (the primitive has no reset); they are don't-care while cnt=0.
- Derived signals:
  - IN_READY = (cnt != 16). Registered state only; no combinational path from OUT_READY.
  - push = IN_VALID & IN_READY & ~FLUSH.
  - load = (cnt != 0) & (~OUT_VALID | OUT_READY) & ~FLUSH.
  - SRL CE = push; SRL D = IN_DATA.
  - SRL address = cnt-1 when cnt != 0, else 0. The oldest word is always at cnt-1.
- Occupancy counter cnt (5 bits):
  - push only: +1.
  - load only: -1.
  - push and load together: unchanged. Read is combinational before the shift edge; after the shift the next-oldest word sits at the same address.
  - never wraps: push is impossible at 16, load is impossible at 0.
- Output register:
  - load: OUT_DATA <= SRL Q, OUT_VALID <= 1.
  - else if OUT_VALID & OUT_READY: OUT_VALID <= 0, OUT_DATA holds its value.
  - else hold.
- Latency:
  - A word pushed at edge N is in the SRL after N, loads at edge N+1, and OUT_VALID is high in the cycle after N+1.
  - Sustained throughput is 1 word/cycle in both directions when OUT_READY=1.
- Capacity:
  - 17 words total: 16 in the SRL plus 1 in the output register.
  - IN_READY drops when cnt=16, regardless of OUT_READY.
- FLUSH (synchronous):
  - Next edge: cnt=0, OUT_VALID=0.
  - A push presented in the same cycle is dropped; the CE is gated.
  - Overrides push and load in the same cycle.
- Mid-operation reset: all state clears immediately; reads after release return only new data.
- LEVEL = cnt. ALMOST_FULL is combinational from cnt.

Decomposition:
- Shared package srl_fifo_pkg holds:
  - SRL_DEPTH=16, SRL_AW=4, LVL_W=5;
  - helper function for the next-count computation.
- Sub-module: none new. Instantiate the existing SRL16E WIDTH times via a generate loop:
  - INIT=16'h0;
  - common CLK, CE and address;
  - per-bit D and Q.
- Counter, handshake and output register stay in srl16_fifo_ctrl.

Test Plan:
- Reset then idle -> IN_READY=1, OUT_VALID=0, LEVEL=0, OUT_DATA=0.
- Single write 0xA5 at cycle 0, OUT_READY=1 -> OUT_VALID=1 with 0xA5 two cycles after the push edge; LEVEL goes 1 then 0.
- OUT_READY=0, write 0x00..0x10 (17 words) -> IN_READY falls after the 17th accept (LEVEL=16, OUT_DATA=0x00); ALMOST_FULL rises when LEVEL reaches 12. Then OUT_READY=1 -> outputs 0x00..0x10 in order with no gaps.
- Streaming: both sides valid/ready for 100 cycles, incrementing data -> LEVEL constant, in-order output, no bubbles after the initial 2-cycle latency.
- FLUSH asserted with LEVEL=5 and a concurrent push -> next cycle LEVEL=0, OUT_VALID=0; the next word written (0x3C) is the first word out.
- RST_N pulsed low asynchronously mid-stream with LEVEL=9 -> outputs clear without a clock edge; post-release writes 0x11, 0x22 emerge as 0x11, 0x22 only.
